// File: rtl/seq_rotate_right.sv
// Iterative right-rotate / logical right-shift unit, one bit position per clock.
// Operand in and result out each use their own valid/ready handshake.
module seq_rotate_right #(
    parameter int WIDTH = 8,
    parameter int SW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [SW-1:0]    S,
    input  logic             LOG,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] data, data_next;
    logic [SW-1:0]    cnt, cnt_next;
    logic             mode, mode_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            data  <= '0;
            cnt   <= '0;
            mode  <= 1'b0;
        end else begin
            state <= state_next;
            data  <= data_next;
            cnt   <= cnt_next;
            mode  <= mode_next;
        end
    end

    always_comb begin
        state_next = state;
        data_next  = data;
        cnt_next   = cnt;
        mode_next  = mode;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;

        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    data_next  = A;
                    cnt_next   = S;
                    mode_next  = LOG;
                    state_next = (S == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                // mode selects the bit entering at the MSB: zero fill or the wrapped LSB
                data_next = {(mode ? 1'b0 : data[0]), data[WIDTH-1:1]};
                cnt_next  = cnt - 1'b1;
                if (cnt == SW'(1))
                    state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign Y = data;

endmodule
